fetch_sequencer: RTL and testbench

Control FSM that sequences the fetch stage of the LEGv8 core. It owns the fetch PC, issues one instruction-memory request at a time over a req/gnt/rvalid handshake, and delivers each instruction with its PC to decode under a stall backpressure. It arbitrates the PC source between sequential PC+4, branch redirects and exception vectors, and squashes fetches made stale by a redirect.

---
 rtl/fetch_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch-stage control FSM for the LEGv8 core.
// Owns the fetch PC, keeps at most one instruction-memory request in flight,
// hands each fetched word plus its PC to decode under stall backpressure,
// and redirects on taken branches and exceptions, squashing stale fetches.
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When it is defined, a misaligned
// redirect target raises align_fault and parks the FSM in HALT. When it is
// undefined, target bits [1:0] are forced to zero.
`timescale 1ns/1ps
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_valid,
    input  logic [63:0] branch_target,
    input  logic        exc_valid,
    input  logic [63:0] exc_vector,
    input  logic        stall_D,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid_D,
    output logic [31:0] instr_D,
    output logic [63:0] pc_D,
    output logic        redirect_pending,
    output logic        align_fault
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        DELIVER = 3'd3
`ifdef FETCH_ALIGN_CHECK_EN
        , HALT  = 3'd4
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic        pend_exc_q, pend_exc_d;
    logic [63:0] pend_target_q, pend_target_d;
    logic        squash_q, squash_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] pc_q, pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        align_fault_q, align_fault_d;
`endif

    logic        redir_in;
    logic [63:0] in_target;
    logic        m_valid;
    logic        m_exc;
    logic [63:0] m_target;
    logic        load_fault;
    state_e      load_state;
    logic        do_load;

    // Merge this cycle's redirect with the latched one: exceptions win, and a
    // pending exception is never displaced by a branch.
    always_comb begin
        redir_in = exc_valid | branch_valid;
`ifdef FETCH_ALIGN_CHECK_EN
        in_target = exc_valid ? exc_vector : branch_target;
`else
        in_target = (exc_valid ? exc_vector : branch_target) & ~64'h3;
`endif
        m_valid  = pend_valid_q;
        m_exc    = pend_exc_q;
        m_target = pend_target_q;
        if (exc_valid) begin
            m_valid  = 1'b1;
            m_exc    = 1'b1;
            m_target = in_target;
        end else if (branch_valid && !(pend_valid_q && pend_exc_q)) begin
            m_valid  = 1'b1;
            m_exc    = 1'b0;
            m_target = in_target;
        end
`ifdef FETCH_ALIGN_CHECK_EN
        load_fault = (m_target[1:0] != 2'b00);
        load_state = load_fault ? HALT : REQ;
`else
        load_fault = 1'b0;
        load_state = REQ;
`endif
    end

    // Next-state and datapath decode; a redirect load is applied last so it
    // overrides whatever the current state would otherwise do.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pend_valid_d  = pend_valid_q;
        pend_exc_d    = pend_exc_q;
        pend_target_d = pend_target_q;
        squash_d      = squash_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        do_load       = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        align_fault_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (m_valid) begin
                    do_load = 1'b1;
                end
            end
            REQ: begin
                pend_valid_d  = m_valid;
                pend_exc_d    = m_exc;
                pend_target_d = m_target;
                if (redir_in) begin
                    squash_d = 1'b1;
                end
                if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (squash_q || redir_in) begin
                        do_load = 1'b1;
                    end else begin
                        instr_d       = imem_rdata;
                        pc_d          = fetch_pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = DELIVER;
                    end
                end else begin
                    pend_valid_d  = m_valid;
                    pend_exc_d    = m_exc;
                    pend_target_d = m_target;
                    if (redir_in) begin
                        squash_d = 1'b1;
                    end
                end
            end
            DELIVER: begin
                if (redir_in) begin
                    instr_valid_d = 1'b0;
                    do_load       = 1'b1;
                end else if (!stall_D) begin
                    instr_valid_d = 1'b0;
                    fetch_pc_d    = fetch_pc_q + 64'd4;
                    state_d       = REQ;
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            HALT: begin
                if (exc_valid) begin
                    do_load = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_load) begin
            state_d       = load_state;
            fetch_pc_d    = load_fault ? fetch_pc_q : m_target;
            pend_valid_d  = 1'b0;
            pend_exc_d    = 1'b0;
            squash_d      = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            align_fault_d = load_fault;
`endif
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_exc_q    <= 1'b0;
            pend_target_q <= 64'h0;
            squash_q      <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'h0;
            pc_q          <= 64'h0;
`ifdef FETCH_ALIGN_CHECK_EN
            align_fault_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_exc_q    <= pend_exc_d;
            pend_target_q <= pend_target_d;
            squash_q      <= squash_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
            align_fault_q <= align_fault_d;
`endif
        end
    end

    // Request signals are decoded from state; the address reads zero when idle.
    always_comb begin
        imem_req         = (state_q == REQ);
        imem_addr        = imem_req ? fetch_pc_q : 64'h0;
        instr_valid_D    = instr_valid_q;
        instr_D          = instr_q;
        pc_D             = pc_q;
        redirect_pending = pend_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
        align_fault      = align_fault_q;
`else
        align_fault      = 1'b0;
`endif
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios followed by a randomized run against
// a transaction-level model (delivered PCs follow +4 or the winning redirect).
`timescale 1ns/1ps
module tb_fetch_sequencer;

    localparam logic [63:0] RST_PC = 64'h400;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_valid;
    logic [63:0] branch_target;
    logic        exc_valid;
    logic [63:0] exc_vector;
    logic        stall_D;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid_D;
    logic [31:0] instr_D;
    logic [63:0] pc_D;
    logic        redirect_pending;
    logic        align_fault;

    int checks = 0;
    int failures = 0;

    logic [63:0] a;
    logic        busy;
    int          cnt;
    logic [63:0] outAddr;
    logic [63:0] expPc;
    logic        redirOut;
    logic        prevHold;
    logic [63:0] prevAddr;
    int          deliveries;
    logic        g, rv, st, bv, ev;
    logic [31:0] rd;
    logic [63:0] bt, evec;
    int          kind;

    // 100 MHz clock
    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk(clk),
        .reset(reset),
        .branch_valid(branch_valid),
        .branch_target(branch_target),
        .exc_valid(exc_valid),
        .exc_vector(exc_vector),
        .stall_D(stall_D),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .instr_valid_D(instr_valid_D),
        .instr_D(instr_D),
        .pc_D(pc_D),
        .redirect_pending(redirect_pending),
        .align_fault(align_fault)
    );

    // Instruction memory contents as a pure function of the address
    function automatic logic [31:0] memWord(input logic [63:0] adr);
        return (adr[33:2] * 32'h9E3779B1) ^ adr[63:32] ^ 32'h5A5A0F0F;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic gi, input logic rvi, input logic [31:0] rdi,
                                 input logic sti, input logic bvi, input logic [63:0] bti,
                                 input logic evi, input logic [63:0] evv);
        imem_gnt      = gi;
        imem_rvalid   = rvi;
        imem_rdata    = rdi;
        stall_D       = sti;
        branch_valid  = bvi;
        branch_target = bti;
        exc_valid     = evi;
        exc_vector    = evv;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkZeros(input string tag);
        checkOutput({tag, "_req"}, {63'h0, imem_req}, 64'h0);
        checkOutput({tag, "_addr"}, imem_addr, 64'h0);
        checkOutput({tag, "_valid"}, {63'h0, instr_valid_D}, 64'h0);
        checkOutput({tag, "_instr"}, {32'h0, instr_D}, 64'h0);
        checkOutput({tag, "_pc"}, pc_D, 64'h0);
        checkOutput({tag, "_pending"}, {63'h0, redirect_pending}, 64'h0);
        checkOutput({tag, "_align"}, {63'h0, align_fault}, 64'h0);
    endtask

    // Safety net so the run can never hang
    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired before completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        checkZeros("reset");

        reset = 1'b1;
        step();

        for (int k = 0; k < 3; k++) begin
            a = RST_PC + 64'(4 * k);
            checkOutput("seq_req", {63'h0, imem_req}, 64'h1);
            checkOutput("seq_addr", imem_addr, a);
            checkOutput("seq_valid_lo", {63'h0, instr_valid_D}, 64'h0);
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
            step();
            checkOutput("seq_wait_noreq", {63'h0, imem_req}, 64'h0);
            applyStimulus(0, 1, memWord(a), 0, 0, 0, 0, 0);
            step();
            checkOutput("seq_valid", {63'h0, instr_valid_D}, 64'h1);
            checkOutput("seq_pc", pc_D, a);
            checkOutput("seq_instr", {32'h0, instr_D}, {32'h0, memWord(a)});
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end

        checkOutput("br_start_addr", imem_addr, 64'h40C);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 1, 64'h1000, 0, 0);
        step();
        checkOutput("br_pending1", {63'h0, redirect_pending}, 64'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        checkOutput("br_pending2", {63'h0, redirect_pending}, 64'h1);
        checkOutput("br_valid_lo", {63'h0, instr_valid_D}, 64'h0);
        applyStimulus(0, 1, memWord(64'h40C), 0, 0, 0, 0, 0);
        step();
        checkOutput("br_drop_valid", {63'h0, instr_valid_D}, 64'h0);
        checkOutput("br_req", {63'h0, imem_req}, 64'h1);
        checkOutput("br_addr", imem_addr, 64'h1000);
        checkOutput("br_pending_clr", {63'h0, redirect_pending}, 64'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        checkOutput("br_wait_valid_lo", {63'h0, instr_valid_D}, 64'h0);
        applyStimulus(0, 1, memWord(64'h1000), 0, 0, 0, 0, 0);
        step();
        checkOutput("br_target_valid", {63'h0, instr_valid_D}, 64'h1);
        checkOutput("br_target_pc", pc_D, 64'h1000);

        applyStimulus(0, 0, 0, 1, 1, 64'h2000, 1, 64'h80);
        step();
        checkOutput("exc_drop_valid", {63'h0, instr_valid_D}, 64'h0);
        checkOutput("exc_req", {63'h0, imem_req}, 64'h1);
        checkOutput("exc_addr", imem_addr, 64'h80);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 1, memWord(64'h80), 0, 0, 0, 0, 0);
        step();
        checkOutput("exc_pc", pc_D, 64'h80);
        checkOutput("exc_instr", {32'h0, instr_D}, {32'h0, memWord(64'h80)});
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        for (int c = 0; c < 5; c++) begin
            checkOutput("hold_req", {63'h0, imem_req}, 64'h1);
            checkOutput("hold_addr", imem_addr, 64'h84);
            applyStimulus(0, 0, 0, 0, (c == 1), 64'h3000, 0, 0);
            step();
        end
        checkOutput("hold_pending", {63'h0, redirect_pending}, 64'h1);
        checkOutput("hold_addr_final", imem_addr, 64'h84);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 1, memWord(64'h84), 0, 0, 0, 0, 0);
        step();
        checkOutput("hold_squash_valid", {63'h0, instr_valid_D}, 64'h0);
        checkOutput("hold_new_addr", imem_addr, 64'h3000);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 1, memWord(64'h3000), 0, 0, 0, 0, 0);
        step();
        checkOutput("hold_new_pc", pc_D, 64'h3000);

        for (int s = 0; s < 4; s++) begin
            applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
            step();
            checkOutput("stall_valid", {63'h0, instr_valid_D}, 64'h1);
            checkOutput("stall_pc", pc_D, 64'h3000);
            checkOutput("stall_instr", {32'h0, instr_D}, {32'h0, memWord(64'h3000)});
            checkOutput("stall_noreq", {63'h0, imem_req}, 64'h0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        checkOutput("stall_release_req", {63'h0, imem_req}, 64'h1);
        checkOutput("stall_release_addr", imem_addr, 64'h3004);
        checkOutput("stall_release_valid", {63'h0, instr_valid_D}, 64'h0);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'h500);
        step();
        applyStimulus(0, 0, 0, 0, 1, 64'h600, 0, 0);
        step();
        checkOutput("prio_pending", {63'h0, redirect_pending}, 64'h1);
        applyStimulus(0, 1, memWord(64'h3004), 0, 0, 0, 0, 0);
        step();
        checkOutput("prio_exc_kept", imem_addr, 64'h500);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 1, 64'h700, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'h900);
        step();
        applyStimulus(0, 1, memWord(64'h500), 0, 0, 0, 0, 0);
        step();
        checkOutput("prio_exc_over_br", imem_addr, 64'h900);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 1, 64'hA00, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 1, 64'hB00, 0, 0);
        step();
        applyStimulus(0, 1, memWord(64'h900), 0, 0, 0, 0, 0);
        step();
        checkOutput("prio_later_br", imem_addr, 64'hB00);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 1, memWord(64'hB00), 0, 1, 64'hC00, 0, 0);
        step();
        checkOutput("same_cycle_addr", imem_addr, 64'hC00);
        checkOutput("same_cycle_valid", {63'h0, instr_valid_D}, 64'h0);
        checkOutput("same_cycle_pending", {63'h0, redirect_pending}, 64'h0);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 1, memWord(64'hC00), 0, 0, 0, 0, 0);
        step();
        checkOutput("mis_pre_pc", pc_D, 64'hC00);
        applyStimulus(0, 0, 0, 0, 1, 64'h1002, 0, 0);
        step();
`ifdef FETCH_ALIGN_CHECK_EN
        checkOutput("mis_fault", {63'h0, align_fault}, 64'h1);
        checkOutput("mis_noreq", {63'h0, imem_req}, 64'h0);
        applyStimulus(0, 0, 0, 0, 1, 64'h2000, 0, 0);
        step();
        checkOutput("mis_fault_pulse", {63'h0, align_fault}, 64'h0);
        checkOutput("mis_halt_noreq", {63'h0, imem_req}, 64'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'h80);
        step();
        checkOutput("mis_resume_addr", imem_addr, 64'h80);
`else
        checkOutput("mis_nofault", {63'h0, align_fault}, 64'h0);
        checkOutput("mis_masked_addr", imem_addr, 64'h1000);
`endif
        checkOutput("mis_resume_req", {63'h0, imem_req}, 64'h1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        checkZeros("mid_wait_reset");
        reset = 1'b1;
        applyStimulus(0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        step();
        checkOutput("stale_req", {63'h0, imem_req}, 64'h1);
        checkOutput("stale_addr", imem_addr, RST_PC);
        step();
        checkOutput("stale_valid", {63'h0, instr_valid_D}, 64'h0);
        checkOutput("stale_addr2", imem_addr, RST_PC);

        busy = 1'b0;
        cnt = 0;
        outAddr = 64'h0;
        expPc = RST_PC;
        redirOut = 1'b0;
        prevHold = 1'b0;
        prevAddr = 64'h0;
        deliveries = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prevHold) begin
                checkOutput("rnd_hold_req", {63'h0, imem_req}, 64'h1);
                checkOutput("rnd_hold_addr", imem_addr, prevAddr);
            end
            checkOutput("rnd_align", {63'h0, align_fault}, 64'h0);
            if (instr_valid_D) begin
                checkOutput("rnd_pc", pc_D, expPc);
                checkOutput("rnd_instr", {32'h0, instr_D}, {32'h0, memWord(expPc)});
                redirOut = 1'b0;
            end
            rv = 1'b0;
            rd = $urandom;
            if (busy) begin
                if (cnt == 0) begin
                    rv = 1'b1;
                    rd = memWord(outAddr);
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end
            g = 1'b0;
            if (imem_req && !busy) begin
                g = ($urandom_range(0, 3) != 0);
                if (g) begin
                    busy = 1'b1;
                    cnt = $urandom_range(0, 2);
                    outAddr = imem_addr;
                end
            end
            prevHold = imem_req && !g;
            prevAddr = imem_addr;
            st = instr_valid_D ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 1) == 1);
            bt = {32'h0, $urandom};
            evec = {32'h0, $urandom};
`ifdef FETCH_ALIGN_CHECK_EN
            bt = bt & ~64'h3;
            evec = evec & ~64'h3;
`endif
            bv = 1'b0;
            ev = 1'b0;
            if (!redirOut && $urandom_range(0, 15) == 0) begin
                kind = $urandom_range(0, 2);
                bv = (kind != 1);
                ev = (kind != 0);
                expPc = (ev ? evec : bt) & ~64'h3;
                redirOut = 1'b1;
            end else if (instr_valid_D && !st) begin
                expPc = expPc + 64'd4;
                deliveries++;
            end
            applyStimulus(g, rv, rd, st, bv, bt, ev, evec);
            step();
        end
        checkOutput("rnd_progress", {63'h0, (deliveries >= 100)}, 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
